// File: rtl/comparador_pkg.sv
// Shared types and constants for the bit-serial comparator sequencer.
// Holds the FSM state encoding, the default word width and a ceil-log2 helper.
package comparador_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam int COMP_WIDTH_DEF = 8;

    // Never returns less than 1 so a counter built from it always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comparador_serial_d_i_registro.sv
// Parallel-load, right-shift register feeding one operand LSB first.
// Zero fill on the left; load has priority over shift.
module registro_desplazamiento_d_i
    import comparador_pkg::*;
#(
    parameter int WIDTH = COMP_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load_i) begin
            r_q <= d_i;
        end else if (shift_i) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign bit_o = r_q[0];

endmodule

// File: rtl/comparador_serial_d_i.sv
// Bit-serial A<B / A<=B sequencer driving an external borrow cell, LSB first.
// Optional equality output igual_o is built only when COMPARADOR_IGUAL_EN is defined.
module comparador_serial_d_i
    import comparador_pkg::*;
#(
    parameter int WIDTH = COMP_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             x_init_i,
    output logic             a_bit_o,
    output logic             b_bit_o,
    output logic             x_o,
    input  logic             p_i,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             menor_o
`ifdef COMPARADOR_IGUAL_EN
    ,
    output logic             igual_o
`endif
);

    localparam int CW = clog2(WIDTH);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_x;
    logic            r_menor;
    logic            w_load;
    logic            w_shift;
    logic            w_last;

    // A new word pair is accepted from IDLE, or from DONE when the result is taken in the same cycle.
    assign w_load  = start_i && ((r_state == IDLE) || ((r_state == DONE) && res_ready_i));
    assign w_shift = (r_state == SHIFT);
    assign w_last  = w_shift && (r_cnt == '0);

    registro_desplazamiento_d_i #(.WIDTH(WIDTH)) u_reg_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_load),
        .shift_i (w_shift),
        .d_i     (a_i),
        .bit_o   (a_bit_o)
    );

    registro_desplazamiento_d_i #(.WIDTH(WIDTH)) u_reg_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (w_load),
        .shift_i (w_shift),
        .d_i     (b_i),
        .bit_o   (b_bit_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_menor <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_load) begin
                        r_state <= SHIFT;
                        r_x     <= x_init_i;
                        r_cnt   <= CW'(WIDTH - 1);
                    end else if ((r_state == DONE) && res_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_x   <= p_i;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_menor <= p_i;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef COMPARADOR_IGUAL_EN
    logic r_eq_run;
    logic r_igual;

    // The running flag folds in the final bit pair directly so it can be captured alongside menor_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq_run <= 1'b0;
            r_igual  <= 1'b0;
        end else if (w_load) begin
            r_eq_run <= 1'b1;
        end else if (w_shift) begin
            if (a_bit_o != b_bit_o) begin
                r_eq_run <= 1'b0;
            end
            if (w_last) begin
                r_igual <= r_eq_run && (a_bit_o == b_bit_o);
            end
        end
    end

    assign igual_o = r_igual;
`endif

    assign x_o         = r_x;
    assign menor_o     = r_menor;
    assign busy_o      = (r_state == SHIFT);
    assign res_valid_o = (r_state == DONE);

endmodule
